segre_store_buffer: RTL and testbench
=====================================

# segre_store_buffer

Parametrised store buffer sitting between the MEM stage and the data cache write port. It accepts committed stores (byte/half/word), holds them as word-aligned entries with byte enables, forwards data to younger loads, optionally coalesces stores to the same word, and drains entries to the D-cache under a valid/ready handshake. Depth, drain policy and coalescing are parameters.

## Interface
- DEPTH, 4: number of entries (power of two, ≥2).
- ADDR_W, 32: address width.
- DATA_W, 32: data word width (fixed 32 for memop_data_type_e semantics).
- COALESCE, 1: 1 merges a store into the youngest entry on word-address match.
- EAGER_DRAIN, 0: 0 drains only on triggers; 1 drains whenever non-empty.

Clock/reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock.
- rsn_i  in  1  asynchronous active-low reset.
- st_valid_i  in  1  store request.
- st_addr_i  in  ADDR_W  byte address.
- st_data_i  in  DATA_W  store data, right-aligned.
- st_type_i  in  memop_data_type_e  BYTE/HALF/WORD.
- st_ready_o  out  1  store accepted this cycle when high with st_valid_i.
- st_misalign_o  out  1  combinational: current store is misaligned (rejected).
- ld_valid_i  in  1  load lookup.
- ld_addr_i  in  ADDR_W  load byte address.
- ld_type_i  in  memop_data_type_e  load size.
- ld_fwd_hit_o  out  1  all load bytes present in buffer.
- ld_fwd_conflict_o  out  1  some but not all load bytes present.
- ld_fwd_data_o  out  DATA_W  forwarded raw bytes, right-aligned, zero-filled (no sign extension).
- drain_req_i  in  1  level request (fence/flush); held until empty_o.
- dc_wr_valid_o  out  1  head entry presented to D-cache.
- dc_wr_addr_o  out  ADDR_W  word-aligned address (bits [1:0]=0).
- dc_wr_data_o  out  DATA_W  entry data, in lane position.
- dc_wr_be_o  out  DATA_W/8  byte enables.
- dc_wr_ready_i  in  1  D-cache accepts head.
- draining_o  out  1  FSM in DRAIN.
- empty_o, full_o  out  1  occupancy flags.
- count_o  out  $clog2(DEPTH+1)  occupancy.

## Operation
- Entry = {word address ADDR_W-2, data DATA_W, be DATA_W/8}; circular FIFO, head/tail pointers wrap modulo DEPTH.
- Store conversion: off=addr[1:0]; BYTE be=0001<<off; HALF be=0011<<off; WORD be=1111; data shifted left 8*off.
- Misaligned: HALF with off[0]=1, WORD with off≠0 → st_misalign_o=1, st_ready_o=0, nothing enqueued.
- Coalesce (COALESCE=1): word address equals youngest valid entry and that entry is not the head while dc_wr_valid_o=1 → merge: be|=new_be, enabled bytes overwritten. Allowed when full.
- st_ready_o = aligned & (!full_o | coalesce match). Push and retire in same cycle: count unchanged.
- Forwarding (combinational): per needed load byte, take youngest entry whose be covers it. All covered → hit=1; some covered → conflict=1; none → both 0. Outputs 0 when ld_valid_i=0. Bytes uncovered read 0.
- FSM IDLE/DRAIN. IDLE→DRAIN when count>0 and (drain_req_i | full_o | ld_fwd_conflict_o | EAGER_DRAIN). DRAIN: dc_wr_valid_o=1 with head; dc_wr_valid_o & dc_wr_ready_i retires head. DRAIN→IDLE on retire leaving count=0, or on retire when no trigger remains and EAGER_DRAIN=0 (stop-on-trigger-clear).
- Once dc_wr_valid_o rises, addr/data/be/valid stay stable until accepted.

## Timing
- Reset (async): count 0, pointers 0, IDLE; all outputs 0 except empty_o=1. Reset mid-drain drops all entries and dc_wr_valid_o immediately.
- Pushed/merged store visible to forwarding and count_o the cycle after acceptance; retiring entry still forwards in its retire cycle.
- IDLE→DRAIN registered: dc_wr_valid_o first high the cycle after trigger; back-to-back retires at 1 entry/cycle while ready held.
- Trigger evaluated with flags from current registered state; no combinational path dc_wr_ready_i → st_ready_o.

## Test plan
- Reset then push SW 0x100=0xDEADBEEF → next cycle count_o=1; LW 0x100 → hit=1, data 0xDEADBEEF.
- SB 0x203=0xAA, SB 0x201=0x55 (COALESCE=1) → count_o=1, be=1010, data 0xAA005500; LH 0x202 → conflict=1, then DRAIN starts next cycle.
- Fill DEPTH=4 with ready=0 → full_o=1, st_ready_o=0 for new word, dc_wr_valid_o stable; ready=1 for 4 cycles → entries retire in order, empty_o=1.
- SH 0x301 → st_misalign_o=1, st_ready_o=0, count unchanged.
- drain_req_i with 3 entries, ready toggling 1,0,1,1 → 3 retires over 4 cycles, draining_o falls after last, push/retire same cycle keeps count.
- Assert rsn_i low mid-drain → outputs zero immediately, empty_o=1, no further dc_wr_valid_o.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared memory-operation types for the segre load/store path.
package segre_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } memop_data_type_e;
endpackage

// File: rtl/segre_store_buffer.sv
// Store buffer between MEM and the D-cache write port: word-aligned FIFO entries
// with byte enables, youngest-wins load forwarding, optional coalescing, handshake drain.
module segre_store_buffer
  import segre_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter bit          COALESCE    = 1'b1,
  parameter bit          EAGER_DRAIN = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         st_valid_i,
  input  logic [ADDR_W-1:0]            st_addr_i,
  input  logic [DATA_W-1:0]            st_data_i,
  input  memop_data_type_e             st_type_i,
  output logic                         st_ready_o,
  output logic                         st_misalign_o,
  input  logic                         ld_valid_i,
  input  logic [ADDR_W-1:0]            ld_addr_i,
  input  memop_data_type_e             ld_type_i,
  output logic                         ld_fwd_hit_o,
  output logic                         ld_fwd_conflict_o,
  output logic [DATA_W-1:0]            ld_fwd_data_o,
  input  logic                         drain_req_i,
  output logic                         dc_wr_valid_o,
  output logic [ADDR_W-1:0]            dc_wr_addr_o,
  output logic [DATA_W-1:0]            dc_wr_data_o,
  output logic [DATA_W/8-1:0]          dc_wr_be_o,
  input  logic                         dc_wr_ready_i,
  output logic                         draining_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned BE_W  = DATA_W/8;
  localparam int unsigned WA_W  = ADDR_W-2;

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WA_W-1:0]    waddr_q [DEPTH];
  logic [DATA_W-1:0]  data_q  [DEPTH];
  logic [BE_W-1:0]    be_q    [DEPTH];

  logic [PTR_W-1:0]   young_idx;
  logic [BE_W-1:0]    st_be;
  logic [DATA_W-1:0]  st_lane_data;
  logic               st_aligned;
  logic               merge_hit, push_new, push_merge, retire, trigger;

  // Store lane conversion and alignment check
  always_comb begin
    st_be      = '0;
    st_aligned = 1'b1;
    case (st_type_i)
      BYTE:    st_be = BE_W'(4'b0001) << st_addr_i[1:0];
      HALF: begin
        st_be      = BE_W'(4'b0011) << st_addr_i[1:0];
        st_aligned = ~st_addr_i[0];
      end
      WORD: begin
        st_be      = BE_W'(4'b1111);
        st_aligned = (st_addr_i[1:0] == 2'b00);
      end
      default: st_aligned = 1'b0;
    endcase
  end

  assign st_lane_data = st_data_i << {st_addr_i[1:0], 3'b000};
  assign young_idx    = tail_q - PTR_W'(1);
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign count_o      = count_q;

  // The head may not change under an offered D-cache write, so never merge into it then.
  assign merge_hit  = COALESCE && !empty_o
                      && (waddr_q[young_idx] == st_addr_i[ADDR_W-1:2])
                      && !((young_idx == head_q) && dc_wr_valid_o);
  assign st_misalign_o = st_valid_i & ~st_aligned;
  assign st_ready_o    = st_valid_i & st_aligned & (~full_o | merge_hit);
  assign push_merge    = st_ready_o & merge_hit;
  assign push_new      = st_ready_o & ~merge_hit;
  assign retire        = dc_wr_valid_o & dc_wr_ready_i;

  // Forwarding: scan oldest to youngest so younger matches overwrite older bytes
  logic [BE_W-1:0]   ld_need, fwd_cov;
  logic [DATA_W-1:0] fwd_lane;
  logic [PTR_W-1:0]  fwd_idx;

  always_comb begin
    ld_need  = '0;
    fwd_cov  = '0;
    fwd_lane = '0;
    fwd_idx  = '0;
    case (ld_type_i)
      BYTE:    ld_need = BE_W'(4'b0001) << ld_addr_i[1:0];
      HALF:    ld_need = BE_W'(4'b0011) << ld_addr_i[1:0];
      WORD:    ld_need = BE_W'(4'b1111) << ld_addr_i[1:0];
      default: ld_need = '0;
    endcase
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (waddr_q[fwd_idx] == ld_addr_i[ADDR_W-1:2])) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_q[fwd_idx][b] && ld_need[b]) begin
            fwd_cov[b]        = 1'b1;
            fwd_lane[8*b +: 8] = data_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign ld_fwd_hit_o      = ld_valid_i && (ld_need != '0) && (fwd_cov == ld_need);
  assign ld_fwd_conflict_o = ld_valid_i && (fwd_cov != '0) && (fwd_cov != ld_need);
  assign ld_fwd_data_o     = ld_valid_i ? (fwd_lane >> {ld_addr_i[1:0], 3'b000}) : '0;

  assign trigger = drain_req_i | full_o | ld_fwd_conflict_o | EAGER_DRAIN;

  assign count_d = count_q + CNT_W'(push_new) - CNT_W'(retire);
  assign head_d  = head_q + PTR_W'(retire);
  assign tail_d  = tail_q + PTR_W'(push_new);

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty_o && trigger) state_d = DRAIN;
      DRAIN:   if (retire && ((count_d == '0) || !trigger)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dc_wr_valid_o = (state_q == DRAIN);
    draining_o    = (state_q == DRAIN);
  end

  assign dc_wr_addr_o = dc_wr_valid_o ? {waddr_q[head_q], 2'b00} : '0;
  assign dc_wr_data_o = dc_wr_valid_o ? data_q[head_q] : '0;
  assign dc_wr_be_o   = dc_wr_valid_o ? be_q[head_q] : '0;

  // Entry storage carries no reset; occupancy gates every read of it
  always_ff @(posedge clk_i) begin
    if (push_new) begin
      waddr_q[tail_q] <= st_addr_i[ADDR_W-1:2];
      data_q[tail_q]  <= st_lane_data;
      be_q[tail_q]    <= st_be;
    end else if (push_merge) begin
      be_q[young_idx] <= be_q[young_idx] | st_be;
      for (int b = 0; b < BE_W; b++) begin
        if (st_be[b]) data_q[young_idx][8*b +: 8] <= st_lane_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_segre_store_buffer.sv
// Directed bench for segre_store_buffer with a queue-based reference model.
module tb_segre_store_buffer;
  import segre_pkg::*;

  localparam int DEPTH = 4;
  localparam bit COALESCE = 1'b1;
  localparam bit EAGER = 1'b0;

  logic clk, rsn;
  logic st_valid, ld_valid, drain_req, dc_ready;
  logic [31:0] st_addr, st_data, ld_addr;
  memop_data_type_e st_type, ld_type;
  logic st_ready_o, st_misalign_o, ld_fwd_hit_o, ld_fwd_conflict_o;
  logic [31:0] ld_fwd_data_o, dc_wr_addr_o, dc_wr_data_o;
  logic [3:0] dc_wr_be_o;
  logic dc_wr_valid_o, draining_o, empty_o, full_o;
  logic [2:0] count_o;

  int n_chk = 0;
  int n_fail = 0;

  segre_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32),
                       .COALESCE(COALESCE), .EAGER_DRAIN(EAGER)) dut (
    .clk_i(clk), .rsn_i(rsn),
    .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data), .st_type_i(st_type),
    .st_ready_o(st_ready_o), .st_misalign_o(st_misalign_o),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_type_i(ld_type),
    .ld_fwd_hit_o(ld_fwd_hit_o), .ld_fwd_conflict_o(ld_fwd_conflict_o),
    .ld_fwd_data_o(ld_fwd_data_o), .drain_req_i(drain_req),
    .dc_wr_valid_o(dc_wr_valid_o), .dc_wr_addr_o(dc_wr_addr_o),
    .dc_wr_data_o(dc_wr_data_o), .dc_wr_be_o(dc_wr_be_o), .dc_wr_ready_i(dc_ready),
    .draining_o(draining_o), .empty_o(empty_o), .full_o(full_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {logic [29:0] w; logic [31:0] d; logic [3:0] be;} ent_t;
  typedef struct packed {logic hit; logic conf; logic [31:0] data;} fwd_t;
  ent_t q[$];
  bit m_drain = 1'b0;

  function automatic int nbytes(input memop_data_type_e t);
    return (t == BYTE) ? 1 : (t == HALF) ? 2 : 4;
  endfunction

  function automatic bit misal();
    return st_valid && ((st_type == HALF && st_addr[0]) || (st_type == WORD && st_addr[1:0] != 2'b00));
  endfunction

  function automatic bit can_merge();
    return COALESCE && q.size() > 0 && q[q.size()-1].w == st_addr[31:2] && !(q.size() == 1 && m_drain);
  endfunction

  function automatic bit exp_ready();
    return st_valid && !misal() && (q.size() < DEPTH || can_merge());
  endfunction

  function automatic ent_t mk_ent();
    ent_t e;
    int lane;
    e.w = st_addr[31:2]; e.d = '0; e.be = '0;
    for (int j = 0; j < nbytes(st_type); j++) begin
      lane = int'(st_addr[1:0]) + j;
      if (lane < 4) begin
        e.be[lane] = 1'b1;
        e.d[8*lane +: 8] = st_data[8*j +: 8];
      end
    end
    return e;
  endfunction

  function automatic fwd_t fwd();
    fwd_t r;
    int need, found, lane;
    r = '0; need = 0; found = 0;
    if (!ld_valid) return r;
    for (int j = 0; j < nbytes(ld_type); j++) begin
      lane = int'(ld_addr[1:0]) + j;
      if (lane < 4) begin
        need++;
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].w == ld_addr[31:2] && q[i].be[lane]) begin
            r.data[8*j +: 8] = q[i].d[8*lane +: 8];
            found++;
            break;
          end
        end
      end
    end
    r.hit  = (need > 0) && (found == need);
    r.conf = (found > 0) && (found < need);
    return r;
  endfunction

  always @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      q.delete();
      m_drain = 1'b0;
    end else begin
      fwd_t f;
      ent_t e, t;
      int sz;
      bit ret, pushing, mrg, trig;
      sz = q.size();
      f = fwd();
      ret = m_drain && dc_ready;
      pushing = exp_ready();
      mrg = pushing && can_merge();
      trig = drain_req || (sz == DEPTH) || f.conf || EAGER;
      e = mk_ent();
      if (mrg) begin
        t = q[sz-1];
        for (int l = 0; l < 4; l++)
          if (e.be[l]) t.d[8*l +: 8] = e.d[8*l +: 8];
        t.be = t.be | e.be;
        q[sz-1] = t;
      end
      if (ret) void'(q.pop_front());
      if (pushing && !mrg) q.push_back(e);
      if (!m_drain) m_drain = (sz > 0) && trig;
      else if (ret && (q.size() == 0 || !trig)) m_drain = 1'b0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    fwd_t f;
    bit v;
    f = fwd();
    v = m_drain && q.size() > 0;
    chk("count", 32'(count_o), 32'(q.size()));
    chk("empty", 32'(empty_o), 32'(q.size() == 0));
    chk("full", 32'(full_o), 32'(q.size() == DEPTH));
    chk("st_ready", 32'(st_ready_o), 32'(exp_ready()));
    chk("st_misalign", 32'(st_misalign_o), 32'(misal()));
    chk("fwd_hit", 32'(ld_fwd_hit_o), 32'(f.hit));
    chk("fwd_conflict", 32'(ld_fwd_conflict_o), 32'(f.conf));
    chk("fwd_data", ld_fwd_data_o, f.data);
    chk("dc_valid", 32'(dc_wr_valid_o), 32'(v));
    chk("draining", 32'(draining_o), 32'(v));
    chk("dc_addr", dc_wr_addr_o, v ? {q[0].w, 2'b00} : 32'h0);
    chk("dc_data", dc_wr_data_o, v ? q[0].d : 32'h0);
    chk("dc_be", 32'(dc_wr_be_o), v ? 32'(q[0].be) : 32'h0);
  end

  // ---------------- stimulus ----------------
  logic last_ready;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input memop_data_type_e t);
    st_valid = 1'b1; st_addr = a; st_data = d; st_type = t;
    #2;
    last_ready = st_ready_o;
    step();
    st_valid = 1'b0;
  endtask

  task automatic drain_all();
    bit done;
    done = 1'b0;
    drain_req = 1'b1; dc_ready = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      done = empty_o && !draining_o;
    end
    drain_req = 1'b0; dc_ready = 1'b0;
    chk("drain_all_done", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rsn = 1'b0; st_valid = 1'b0; ld_valid = 1'b0; drain_req = 1'b0; dc_ready = 1'b0;
    st_addr = '0; st_data = '0; ld_addr = '0; st_type = BYTE; ld_type = BYTE;
    repeat (2) step();
    rsn = 1'b1;
    #2;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_dc_valid", 32'(dc_wr_valid_o), 32'd0);
    chk("rst_st_ready", 32'(st_ready_o), 32'd0);
    step();

    // Word store then forwarded word load
    st(32'h100, 32'hDEADBEEF, WORD);
    chk("sw_ready", 32'(last_ready), 32'd1);
    ld_valid = 1'b1; ld_addr = 32'h100; ld_type = WORD;
    #2;
    chk("sw_count", 32'(count_o), 32'd1);
    chk("lw_hit", 32'(ld_fwd_hit_o), 32'd1);
    chk("lw_data", ld_fwd_data_o, 32'hDEADBEEF);
    ld_valid = 1'b0;
    drain_all();

    // Coalesced bytes, partial load conflict triggers drain
    st(32'h203, 32'h000000AA, BYTE);
    st(32'h201, 32'h00000055, BYTE);
    #2;
    chk("coal_count", 32'(count_o), 32'd1);
    ld_valid = 1'b1; ld_addr = 32'h202; ld_type = HALF;
    #2;
    chk("lh_conflict", 32'(ld_fwd_conflict_o), 32'd1);
    chk("lh_hit", 32'(ld_fwd_hit_o), 32'd0);
    chk("lh_data", ld_fwd_data_o, 32'h0000AA00);
    step();
    #2;
    chk("conf_draining", 32'(draining_o), 32'd1);
    chk("coal_be", 32'(dc_wr_be_o), 32'h0000000A);
    chk("coal_data", dc_wr_data_o, 32'hAA005500);
    chk("coal_addr", dc_wr_addr_o, 32'h00000200);
    ld_valid = 1'b0;
    drain_all();

    // Fill to full with D-cache stalled
    for (int i = 0; i < 4; i++) st(32'h400 + 32'(4*i), 32'h10101010 * 32'(i+1), WORD);
    st_valid = 1'b1; st_addr = 32'h500; st_data = 32'h55555555; st_type = WORD;
    #2;
    chk("full_flag", 32'(full_o), 32'd1);
    chk("full_st_ready", 32'(st_ready_o), 32'd0);
    step();
    #2;
    chk("full_dc_valid", 32'(dc_wr_valid_o), 32'd1);
    chk("full_head_addr", dc_wr_addr_o, 32'h400);
    step();
    #2;
    chk("stall_head_addr", dc_wr_addr_o, 32'h400);
    chk("stall_head_data", dc_wr_data_o, 32'h10101010);
    st_valid = 1'b0;
    drain_req = 1'b1; dc_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("order_addr", dc_wr_addr_o, 32'h400 + 32'(4*k));
      step();
    end
    #2;
    chk("order_empty", 32'(empty_o), 32'd1);
    chk("order_idle", 32'(draining_o), 32'd0);
    drain_req = 1'b0; dc_ready = 1'b0;

    // Misaligned half store
    st_valid = 1'b1; st_addr = 32'h301; st_data = 32'h1234; st_type = HALF;
    #2;
    chk("mis_flag", 32'(st_misalign_o), 32'd1);
    chk("mis_ready", 32'(st_ready_o), 32'd0);
    step();
    st_valid = 1'b0;
    #2;
    chk("mis_count", 32'(count_o), 32'd0);

    // Drain request with ready pattern 1,0,1,1
    st(32'h600, 32'hA0A0A0A0, WORD);
    st(32'h604, 32'hB0B0B0B0, WORD);
    st(32'h608, 32'hC0C0C0C0, WORD);
    drain_req = 1'b1; dc_ready = 1'b1;
    step();
    step();
    dc_ready = 1'b0;
    #2;
    chk("tog_count", 32'(count_o), 32'd2);
    step();
    dc_ready = 1'b1;
    step();
    step();
    #2;
    chk("tog_empty", 32'(empty_o), 32'd1);
    chk("tog_idle", 32'(draining_o), 32'd0);
    drain_req = 1'b0; dc_ready = 1'b0;

    // Push and retire in the same cycle
    st(32'h700, 32'h07000700, WORD);
    st(32'h704, 32'h07040704, WORD);
    drain_req = 1'b1; dc_ready = 1'b1;
    step();
    st(32'h708, 32'h07080708, WORD);
    chk("pr_ready", 32'(last_ready), 32'd1);
    #2;
    chk("pr_count", 32'(count_o), 32'd2);
    drain_all();

    // No merge into a head that is being offered
    st(32'h800, 32'h12345678, WORD);
    drain_req = 1'b1; dc_ready = 1'b0;
    step();
    st(32'h801, 32'h00000099, BYTE);
    #2;
    chk("nomerge_count", 32'(count_o), 32'd2);
    chk("nomerge_head", dc_wr_data_o, 32'h12345678);
    drain_all();

    // Youngest entry wins per byte
    st(32'h900, 32'h11223344, WORD);
    st(32'h904, 32'hCAFEF00D, WORD);
    st(32'h901, 32'h00000077, BYTE);
    ld_valid = 1'b1; ld_addr = 32'h900; ld_type = WORD;
    #2;
    chk("yw_hit", 32'(ld_fwd_hit_o), 32'd1);
    chk("yw_data", ld_fwd_data_o, 32'h11227744);
    ld_addr = 32'h905; ld_type = BYTE;
    #2;
    chk("lb_data", ld_fwd_data_o, 32'h000000F0);
    ld_valid = 1'b0;
    drain_all();

    // Asynchronous reset in the middle of a drain
    st(32'hA00, 32'hAAAA0000, WORD);
    st(32'hA04, 32'hAAAA0004, WORD);
    drain_req = 1'b1; dc_ready = 1'b0;
    step();
    #2;
    chk("pre_rst_valid", 32'(dc_wr_valid_o), 32'd1);
    #1;
    rsn = 1'b0;
    #1;
    chk("arst_valid", 32'(dc_wr_valid_o), 32'd0);
    chk("arst_empty", 32'(empty_o), 32'd1);
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_addr", dc_wr_addr_o, 32'h0);
    drain_req = 1'b0;
    step();
    step();
    rsn = 1'b1;
    step();
    step();
    #2;
    chk("post_rst_valid", 32'(dc_wr_valid_o), 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
